// File: rtl/scr1_pipe_lsu_mo_pkg.sv
// Shared LSU types: EXU command, DMEM command/width/response, exception codes and
// the pending-transaction record kept per outstanding DMEM access.
package scr1_pipe_lsu_mo_pkg;

  localparam int unsigned SCR1_LSU_OUTSTD_DEPTH_DFLT = 2;

  typedef enum logic [3:0] {
    SCR1_LSU_CMD_NONE = 4'd0,
    SCR1_LSU_CMD_LB   = 4'd1,
    SCR1_LSU_CMD_LH   = 4'd2,
    SCR1_LSU_CMD_LW   = 4'd3,
    SCR1_LSU_CMD_LBU  = 4'd4,
    SCR1_LSU_CMD_LHU  = 4'd5,
    SCR1_LSU_CMD_SB   = 4'd6,
    SCR1_LSU_CMD_SH   = 4'd7,
    SCR1_LSU_CMD_SW   = 4'd8
  } type_scr1_lsu_cmd_sel_e;

  typedef enum logic {
    SCR1_MEM_CMD_RD = 1'b0,
    SCR1_MEM_CMD_WR = 1'b1
  } type_scr1_mem_cmd_e;

  typedef enum logic [1:0] {
    SCR1_MEM_WIDTH_BYTE  = 2'b00,
    SCR1_MEM_WIDTH_HWORD = 2'b01,
    SCR1_MEM_WIDTH_WORD  = 2'b10
  } type_scr1_mem_width_e;

  typedef enum logic [1:0] {
    SCR1_MEM_RESP_NOTRDY = 2'b00,
    SCR1_MEM_RESP_RDY_OK = 2'b01,
    SCR1_MEM_RESP_RDY_ER = 2'b10
  } type_scr1_mem_resp_e;

  typedef enum logic [3:0] {
    SCR1_EXC_CODE_INSTR_MISALIGN      = 4'd0,
    SCR1_EXC_CODE_LD_ADDR_MISALIGN    = 4'd4,
    SCR1_EXC_CODE_LD_ACCESS_FAULT     = 4'd5,
    SCR1_EXC_CODE_ST_ADDR_MISALIGN    = 4'd6,
    SCR1_EXC_CODE_ST_AMO_ACCESS_FAULT = 4'd7
  } type_scr1_exc_code_e;

  typedef struct packed {
    type_scr1_lsu_cmd_sel_e cmd;
    logic [1:0]             off;
  } type_scr1_lsu_pend_s;

  function automatic logic scr1_lsu_cmd_is_load(input type_scr1_lsu_cmd_sel_e cmd);
    return cmd inside {SCR1_LSU_CMD_LB, SCR1_LSU_CMD_LH, SCR1_LSU_CMD_LW,
                       SCR1_LSU_CMD_LBU, SCR1_LSU_CMD_LHU};
  endfunction

endpackage

// File: rtl/scr1_pipe_lsu_mo_if.sv
// EXU<->LSU and LSU<->DMEM signal bundle. The LSU takes the slave view; the
// surrounding pipeline/memory model takes the master view.
interface scr1_pipe_lsu_mo_if
  import scr1_pipe_lsu_mo_pkg::*;
#(
  parameter int unsigned XLEN = 32
) ();

  logic                   exu2lsu_req;
  type_scr1_lsu_cmd_sel_e exu2lsu_cmd;
  logic [XLEN-1:0]        exu2lsu_addr;
  logic [XLEN-1:0]        exu2lsu_s_data;
  logic                   lsu2exu_req_ack;
  logic                   lsu2exu_rsp_vd;
  logic [XLEN-1:0]        lsu2exu_l_data;
  logic                   lsu2exu_exc;
  type_scr1_exc_code_e    lsu2exu_exc_code;
  logic                   lsu_busy;

  logic                   lsu2dmem_req;
  type_scr1_mem_cmd_e     lsu2dmem_cmd;
  type_scr1_mem_width_e   lsu2dmem_width;
  logic [XLEN-1:0]        lsu2dmem_addr;
  logic [XLEN/8-1:0]      lsu2dmem_be;
  logic [XLEN-1:0]        lsu2dmem_wdata;
  logic                   dmem2lsu_req_ack;
  logic [XLEN-1:0]        dmem2lsu_rdata;
  type_scr1_mem_resp_e    dmem2lsu_resp;

  modport master (
    output exu2lsu_req, exu2lsu_cmd, exu2lsu_addr, exu2lsu_s_data,
    output dmem2lsu_req_ack, dmem2lsu_rdata, dmem2lsu_resp,
    input  lsu2exu_req_ack, lsu2exu_rsp_vd, lsu2exu_l_data, lsu2exu_exc, lsu2exu_exc_code,
    input  lsu_busy,
    input  lsu2dmem_req, lsu2dmem_cmd, lsu2dmem_width, lsu2dmem_addr, lsu2dmem_be,
    input  lsu2dmem_wdata
  );

  modport slave (
    input  exu2lsu_req, exu2lsu_cmd, exu2lsu_addr, exu2lsu_s_data,
    input  dmem2lsu_req_ack, dmem2lsu_rdata, dmem2lsu_resp,
    output lsu2exu_req_ack, lsu2exu_rsp_vd, lsu2exu_l_data, lsu2exu_exc, lsu2exu_exc_code,
    output lsu_busy,
    output lsu2dmem_req, lsu2dmem_cmd, lsu2dmem_width, lsu2dmem_addr, lsu2dmem_be,
    output lsu2dmem_wdata
  );

endinterface

// File: rtl/scr1_lsu_pend_fifo.sv
// In-order record of outstanding DMEM transactions; head is the oldest entry.
// Any depth >= 1 is supported, pointers wrap explicitly at DEPTH-1.
module scr1_lsu_pend_fifo
  import scr1_pipe_lsu_mo_pkg::*;
#(
  parameter int unsigned DEPTH = SCR1_LSU_OUTSTD_DEPTH_DFLT,
  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1,
  localparam int unsigned CntW = $clog2(DEPTH + 1)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                i_push,
  input  logic                i_pop,
  input  type_scr1_lsu_pend_s i_wdata,
  output type_scr1_lsu_pend_s o_head,
  output logic                o_full,
  output logic                o_empty,
  output logic [CntW-1:0]     o_count
);

  type_scr1_lsu_pend_s r_mem [DEPTH];
  logic [PtrW-1:0]     r_wptr;
  logic [PtrW-1:0]     r_rptr;
  logic [CntW-1:0]     r_cnt;
  logic [CntW-1:0]     w_cnt_next;

  function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
    return (p == PtrW'(DEPTH - 1)) ? '0 : p + PtrW'(1);
  endfunction

  always_comb begin
    w_cnt_next = r_cnt;
    if (i_push && !i_pop) begin
      w_cnt_next = r_cnt + CntW'(1);
    end else if (i_pop && !i_push) begin
      w_cnt_next = r_cnt - CntW'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wptr <= '0;
      r_rptr <= '0;
      r_cnt  <= '0;
      for (int unsigned i = 0; i < DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else begin
      if (i_push) begin
        r_mem[r_wptr] <= i_wdata;
        r_wptr        <= ptr_inc(r_wptr);
      end
      if (i_pop) begin
        r_rptr <= ptr_inc(r_rptr);
      end
      r_cnt <= w_cnt_next;
    end
  end

  assign o_head  = r_mem[r_rptr];
  assign o_full  = (r_cnt == CntW'(DEPTH));
  assign o_empty = (r_cnt == '0);
  assign o_count = r_cnt;

endmodule

// File: rtl/scr1_pipe_lsu_mo.sv
// Pipelined LSU: issues up to LSU_OUTSTD_DEPTH DMEM accesses, aligns store lanes,
// extracts/extends load data and returns responses/exceptions in program order.
module scr1_pipe_lsu_mo
  import scr1_pipe_lsu_mo_pkg::*;
#(
  parameter int unsigned LSU_OUTSTD_DEPTH = SCR1_LSU_OUTSTD_DEPTH_DFLT,
  parameter int unsigned LSU_XLEN         = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  scr1_pipe_lsu_mo_if.slave lsu_if
);

  localparam int unsigned NB   = LSU_XLEN / 8;
  localparam int unsigned CntW = $clog2(LSU_OUTSTD_DEPTH + 1);

  logic                 w_is_ld;
  logic                 w_is_st;
  logic                 w_misalign;
  type_scr1_mem_width_e w_width;
  logic [1:0]           w_off;
  logic                 w_full;
  logic                 w_empty;
  logic [CntW-1:0]      w_cnt;
  type_scr1_lsu_pend_s  w_head;
  type_scr1_lsu_pend_s  w_push_data;
  logic                 w_dmem_req;
  logic                 w_push;
  logic                 w_rsp_rdy;
  logic                 w_pop;
  logic                 w_mis_rpt;
  logic [LSU_XLEN-1:0]  w_word;
  logic [LSU_XLEN-1:0]  w_ldata;
  logic [NB-1:0]        w_be;
  logic [LSU_XLEN-1:0]  w_wdata;

  assign w_off = lsu_if.exu2lsu_addr[1:0];

  always_comb begin
    w_is_ld    = 1'b0;
    w_is_st    = 1'b0;
    w_misalign = 1'b0;
    w_width    = SCR1_MEM_WIDTH_WORD;
    case (lsu_if.exu2lsu_cmd)
      SCR1_LSU_CMD_LB, SCR1_LSU_CMD_LBU: begin
        w_is_ld = 1'b1;
        w_width = SCR1_MEM_WIDTH_BYTE;
      end
      SCR1_LSU_CMD_LH, SCR1_LSU_CMD_LHU: begin
        w_is_ld    = 1'b1;
        w_width    = SCR1_MEM_WIDTH_HWORD;
        w_misalign = w_off[0];
      end
      SCR1_LSU_CMD_LW: begin
        w_is_ld    = 1'b1;
        w_misalign = |w_off;
      end
      SCR1_LSU_CMD_SB: begin
        w_is_st = 1'b1;
        w_width = SCR1_MEM_WIDTH_BYTE;
      end
      SCR1_LSU_CMD_SH: begin
        w_is_st    = 1'b1;
        w_width    = SCR1_MEM_WIDTH_HWORD;
        w_misalign = w_off[0];
      end
      SCR1_LSU_CMD_SW: begin
        w_is_st    = 1'b1;
        w_misalign = |w_off;
      end
      default: ;
    endcase
  end

  // Full blocks issue regardless of a same-cycle pop: no response->request comb path.
  assign w_dmem_req  = lsu_if.exu2lsu_req && !w_misalign && !w_full;
  assign w_push      = w_dmem_req && lsu_if.dmem2lsu_req_ack;
  assign w_rsp_rdy   = (lsu_if.dmem2lsu_resp == SCR1_MEM_RESP_RDY_OK) ||
                       (lsu_if.dmem2lsu_resp == SCR1_MEM_RESP_RDY_ER);
  assign w_pop       = w_rsp_rdy && !w_empty;
  // A misaligned request waits until every older access has responded.
  assign w_mis_rpt   = lsu_if.exu2lsu_req && w_misalign && w_empty && !w_pop;
  assign w_push_data = '{cmd: lsu_if.exu2lsu_cmd, off: w_off};

  scr1_lsu_pend_fifo #(
    .DEPTH (LSU_OUTSTD_DEPTH)
  ) u_pend_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_push  (w_push),
    .i_pop   (w_pop),
    .i_wdata (w_push_data),
    .o_head  (w_head),
    .o_full  (w_full),
    .o_empty (w_empty),
    .o_count (w_cnt)
  );

  always_comb begin
    w_be    = '1;
    w_wdata = lsu_if.exu2lsu_s_data;
    case (w_width)
      SCR1_MEM_WIDTH_BYTE: begin
        w_be    = NB'(1) << w_off;
        w_wdata = {NB{lsu_if.exu2lsu_s_data[7:0]}};
      end
      SCR1_MEM_WIDTH_HWORD: begin
        w_be    = NB'(3) << w_off;
        w_wdata = {(NB/2){lsu_if.exu2lsu_s_data[15:0]}};
      end
      default: ;
    endcase
  end

  assign lsu_if.lsu2dmem_req   = w_dmem_req;
  assign lsu_if.lsu2dmem_cmd   = (w_dmem_req && w_is_st) ? SCR1_MEM_CMD_WR : SCR1_MEM_CMD_RD;
  assign lsu_if.lsu2dmem_width = w_dmem_req ? w_width : SCR1_MEM_WIDTH_BYTE;
  assign lsu_if.lsu2dmem_addr  = w_dmem_req ? lsu_if.exu2lsu_addr : '0;
  assign lsu_if.lsu2dmem_be    = w_dmem_req ? w_be : '0;
  assign lsu_if.lsu2dmem_wdata = (w_dmem_req && w_is_st) ? w_wdata : '0;

  assign w_word = lsu_if.dmem2lsu_rdata >> {w_head.off, 3'b000};

  always_comb begin
    w_ldata = w_word;
    case (w_head.cmd)
      SCR1_LSU_CMD_LB:  w_ldata = {{(LSU_XLEN-8){w_word[7]}}, w_word[7:0]};
      SCR1_LSU_CMD_LBU: w_ldata = {{(LSU_XLEN-8){1'b0}}, w_word[7:0]};
      SCR1_LSU_CMD_LH:  w_ldata = {{(LSU_XLEN-16){w_word[15]}}, w_word[15:0]};
      SCR1_LSU_CMD_LHU: w_ldata = {{(LSU_XLEN-16){1'b0}}, w_word[15:0]};
      default: ;
    endcase
  end

  // DMEM response has priority over a misalign report on the response outputs.
  always_comb begin
    lsu_if.lsu2exu_rsp_vd   = 1'b0;
    lsu_if.lsu2exu_l_data   = '0;
    lsu_if.lsu2exu_exc      = 1'b0;
    lsu_if.lsu2exu_exc_code = SCR1_EXC_CODE_INSTR_MISALIGN;
    if (w_pop) begin
      lsu_if.lsu2exu_rsp_vd = 1'b1;
      if (lsu_if.dmem2lsu_resp == SCR1_MEM_RESP_RDY_ER) begin
        lsu_if.lsu2exu_exc      = 1'b1;
        lsu_if.lsu2exu_exc_code = scr1_lsu_cmd_is_load(w_head.cmd) ?
                                  SCR1_EXC_CODE_LD_ACCESS_FAULT :
                                  SCR1_EXC_CODE_ST_AMO_ACCESS_FAULT;
      end else if (scr1_lsu_cmd_is_load(w_head.cmd)) begin
        lsu_if.lsu2exu_l_data = w_ldata;
      end
    end else if (w_mis_rpt) begin
      lsu_if.lsu2exu_rsp_vd   = 1'b1;
      lsu_if.lsu2exu_exc      = 1'b1;
      lsu_if.lsu2exu_exc_code = w_is_ld ? SCR1_EXC_CODE_LD_ADDR_MISALIGN :
                                          SCR1_EXC_CODE_ST_ADDR_MISALIGN;
    end
  end

  assign lsu_if.lsu2exu_req_ack = w_push || w_mis_rpt;
  assign lsu_if.lsu_busy        = (w_cnt != '0);

  a_no_rsp_when_empty : assert property (@(posedge clk) disable iff (!rst_n)
    w_pop |-> !w_empty);
  a_no_push_when_full : assert property (@(posedge clk) disable iff (!rst_n)
    w_push |-> !w_full);
  a_exc_src_onehot : assert property (@(posedge clk) disable iff (!rst_n)
    $onehot0({w_pop, w_mis_rpt}));
  a_req_known : assert property (@(posedge clk) disable iff (!rst_n)
    !$isunknown(lsu_if.exu2lsu_req));
  a_cmd_known : assert property (@(posedge clk) disable iff (!rst_n)
    lsu_if.exu2lsu_req |-> !$isunknown(lsu_if.exu2lsu_cmd));

endmodule

// File: tb/tb_scr1_pipe_lsu_mo.sv
// Directed bench for scr1_pipe_lsu_mo: alignment, extension, outstanding depth,
// misalign ordering, access faults and mid-operation reset.
module tb_scr1_pipe_lsu_mo;
  import scr1_pipe_lsu_mo_pkg::*;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_errors;

  scr1_pipe_lsu_mo_if #(.XLEN(32)) u_if ();

  scr1_pipe_lsu_mo #(
    .LSU_OUTSTD_DEPTH (2),
    .LSU_XLEN         (32)
  ) u_dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .lsu_if (u_if.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    u_if.exu2lsu_req      = 1'b0;
    u_if.exu2lsu_cmd      = SCR1_LSU_CMD_NONE;
    u_if.exu2lsu_addr     = '0;
    u_if.exu2lsu_s_data   = '0;
    u_if.dmem2lsu_req_ack = 1'b0;
    u_if.dmem2lsu_rdata   = '0;
    u_if.dmem2lsu_resp    = SCR1_MEM_RESP_NOTRDY;
  endtask

  task automatic set_req(input type_scr1_lsu_cmd_sel_e cmd, input logic [31:0] addr,
                         input logic [31:0] sd, input logic ack);
    u_if.exu2lsu_req      = 1'b1;
    u_if.exu2lsu_cmd      = cmd;
    u_if.exu2lsu_addr     = addr;
    u_if.exu2lsu_s_data   = sd;
    u_if.dmem2lsu_req_ack = ack;
  endtask

  task automatic set_rsp(input type_scr1_mem_resp_e r, input logic [31:0] d);
    u_if.dmem2lsu_resp  = r;
    u_if.dmem2lsu_rdata = d;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    idle();
    step();
    step();
    n_checks++; if (u_if.lsu_busy !== 1'b0) begin n_errors++;
      $display("FAIL rst_busy got %b want 0", u_if.lsu_busy); end
    n_checks++; if (u_if.lsu2dmem_req !== 1'b0) begin n_errors++;
      $display("FAIL rst_dmem_req got %b want 0", u_if.lsu2dmem_req); end
    rst_n = 1'b1;
    step();
    n_checks++; if (u_if.lsu2exu_rsp_vd !== 1'b0) begin n_errors++;
      $display("FAIL rst_rsp_vd got %b want 0", u_if.lsu2exu_rsp_vd); end
    n_checks++; if (u_if.lsu2exu_req_ack !== 1'b0) begin n_errors++;
      $display("FAIL rst_req_ack got %b want 0", u_if.lsu2exu_req_ack); end
    n_checks++; if ({u_if.lsu2exu_l_data, u_if.lsu2dmem_be, u_if.lsu2dmem_addr} !== '0) begin
      n_errors++; $display("FAIL rst_data got %h/%h/%h want 0", u_if.lsu2exu_l_data,
                           u_if.lsu2dmem_be, u_if.lsu2dmem_addr); end
  endtask

  task automatic test_lw();
    set_req(SCR1_LSU_CMD_LW, 32'h100, 32'h0, 1'b1);
    #1;
    n_checks++; if ({u_if.lsu2dmem_req, u_if.lsu2exu_req_ack} !== 2'b11) begin n_errors++;
      $display("FAIL lw_issue got req/ack %b%b want 11", u_if.lsu2dmem_req,
               u_if.lsu2exu_req_ack); end
    n_checks++; if (u_if.lsu2dmem_cmd !== SCR1_MEM_CMD_RD || u_if.lsu2dmem_width !==
        SCR1_MEM_WIDTH_WORD || u_if.lsu2dmem_be !== 4'hF || u_if.lsu2dmem_addr !== 32'h100) begin
      n_errors++; $display("FAIL lw_bus got cmd %0d width %0d be %h addr %h want 0 2 f 100",
                           u_if.lsu2dmem_cmd, u_if.lsu2dmem_width, u_if.lsu2dmem_be,
                           u_if.lsu2dmem_addr); end
    step();
    idle();
    set_rsp(SCR1_MEM_RESP_RDY_OK, 32'hDEADBEEF);
    #1;
    n_checks++; if (u_if.lsu_busy !== 1'b1) begin n_errors++;
      $display("FAIL lw_busy1 got %b want 1", u_if.lsu_busy); end
    n_checks++; if (u_if.lsu2exu_rsp_vd !== 1'b1 || u_if.lsu2exu_l_data !== 32'hDEADBEEF ||
                    u_if.lsu2exu_exc !== 1'b0) begin n_errors++;
      $display("FAIL lw_rsp got vd %b data %h exc %b want 1 deadbeef 0", u_if.lsu2exu_rsp_vd,
               u_if.lsu2exu_l_data, u_if.lsu2exu_exc); end
    step();
    idle();
    #1;
    n_checks++; if (u_if.lsu_busy !== 1'b0 || u_if.lsu2exu_rsp_vd !== 1'b0) begin n_errors++;
      $display("FAIL lw_done got busy %b vd %b want 0 0", u_if.lsu_busy,
               u_if.lsu2exu_rsp_vd); end
  endtask

  task automatic test_load_ext();
    type_scr1_lsu_cmd_sel_e cmds [8] = '{SCR1_LSU_CMD_LB, SCR1_LSU_CMD_LBU, SCR1_LSU_CMD_LHU,
        SCR1_LSU_CMD_LH, SCR1_LSU_CMD_LH, SCR1_LSU_CMD_LHU, SCR1_LSU_CMD_LB, SCR1_LSU_CMD_LBU};
    logic [31:0] addrs [8] = '{32'h103, 32'h103, 32'h102, 32'h102, 32'h100, 32'h100, 32'h101,
                               32'h100};
    logic [3:0]  bes   [8] = '{4'b1000, 4'b1000, 4'b1100, 4'b1100, 4'b0011, 4'b0011, 4'b0010,
                               4'b0001};
    logic [31:0] exps  [8] = '{32'hFFFFFF80, 32'h00000080, 32'h000080FF, 32'hFFFF80FF,
                               32'hFFFFFFFF, 32'h0000FFFF, 32'hFFFFFFFF, 32'h000000FF};
    for (int i = 0; i < 8; i++) begin
      set_req(cmds[i], addrs[i], 32'h0, 1'b1);
      #1;
      n_checks++; if (u_if.lsu2dmem_be !== bes[i] || u_if.lsu2exu_req_ack !== 1'b1) begin
        n_errors++; $display("FAIL ld_be[%0d] got be %b ack %b want %b 1", i,
                             u_if.lsu2dmem_be, u_if.lsu2exu_req_ack, bes[i]); end
      step();
      idle();
      set_rsp(SCR1_MEM_RESP_RDY_OK, 32'h80FFFFFF);
      #1;
      n_checks++; if (u_if.lsu2exu_l_data !== exps[i]) begin n_errors++;
        $display("FAIL ld_ext[%0d] got %h want %h", i, u_if.lsu2exu_l_data, exps[i]); end
      step();
      idle();
    end
  endtask

  task automatic test_store();
    type_scr1_lsu_cmd_sel_e cmds [3] = '{SCR1_LSU_CMD_SB, SCR1_LSU_CMD_SH, SCR1_LSU_CMD_SW};
    logic [31:0] addrs [3] = '{32'h101, 32'h102, 32'h104};
    logic [31:0] sds   [3] = '{32'h000000A5, 32'h0000BEEF, 32'h12345678};
    logic [3:0]  bes   [3] = '{4'b0010, 4'b1100, 4'b1111};
    logic [31:0] wds   [3] = '{32'hA5A5A5A5, 32'hBEEFBEEF, 32'h12345678};
    type_scr1_mem_width_e wids [3] = '{SCR1_MEM_WIDTH_BYTE, SCR1_MEM_WIDTH_HWORD,
                                       SCR1_MEM_WIDTH_WORD};
    for (int i = 0; i < 3; i++) begin
      set_req(cmds[i], addrs[i], sds[i], 1'b1);
      #1;
      n_checks++; if (u_if.lsu2dmem_be !== bes[i] || u_if.lsu2dmem_wdata !== wds[i] ||
                      u_if.lsu2dmem_cmd !== SCR1_MEM_CMD_WR || u_if.lsu2dmem_width !== wids[i])
      begin n_errors++; $display("FAIL st_bus[%0d] got be %b wdata %h cmd %0d width %0d want %b %h 1 %0d",
                          i, u_if.lsu2dmem_be, u_if.lsu2dmem_wdata, u_if.lsu2dmem_cmd,
                          u_if.lsu2dmem_width, bes[i], wds[i], wids[i]); end
      step();
      idle();
      set_rsp(SCR1_MEM_RESP_RDY_OK, 32'hFFFFFFFF);
      #1;
      n_checks++; if (u_if.lsu2exu_rsp_vd !== 1'b1 || u_if.lsu2exu_l_data !== 32'h0) begin
        n_errors++; $display("FAIL st_rsp[%0d] got vd %b data %h want 1 0", i,
                             u_if.lsu2exu_rsp_vd, u_if.lsu2exu_l_data); end
      step();
      idle();
    end
  endtask

  task automatic test_back_to_back();
    set_req(SCR1_LSU_CMD_LBU, 32'h200, 32'h0, 1'b1);
    #1;
    n_checks++; if (u_if.lsu2exu_req_ack !== 1'b1) begin n_errors++;
      $display("FAIL b2b_ack0 got %b want 1", u_if.lsu2exu_req_ack); end
    step();
    set_req(SCR1_LSU_CMD_LBU, 32'h201, 32'h0, 1'b1);
    #1;
    n_checks++; if (u_if.lsu2exu_req_ack !== 1'b1) begin n_errors++;
      $display("FAIL b2b_ack1 got %b want 1", u_if.lsu2exu_req_ack); end
    step();
    set_req(SCR1_LSU_CMD_LBU, 32'h202, 32'h0, 1'b1);
    #1;
    n_checks++; if ({u_if.lsu2dmem_req, u_if.lsu2exu_req_ack, u_if.lsu_busy} !== 3'b001) begin
      n_errors++; $display("FAIL b2b_full got req/ack/busy %b%b%b want 001",
                           u_if.lsu2dmem_req, u_if.lsu2exu_req_ack, u_if.lsu_busy); end
    step();
    set_rsp(SCR1_MEM_RESP_RDY_OK, 32'h44332211);
    #1;
    n_checks++; if (u_if.lsu2exu_rsp_vd !== 1'b1 || u_if.lsu2exu_l_data !== 32'h11 ||
                    u_if.lsu2dmem_req !== 1'b0) begin n_errors++;
      $display("FAIL b2b_pop0 got vd %b data %h req %b want 1 11 0", u_if.lsu2exu_rsp_vd,
               u_if.lsu2exu_l_data, u_if.lsu2dmem_req); end
    step();
    #1;
    n_checks++; if ({u_if.lsu2dmem_req, u_if.lsu2exu_req_ack} !== 2'b11 ||
                    u_if.lsu2dmem_be !== 4'b0100 || u_if.lsu2exu_l_data !== 32'h22) begin
      n_errors++; $display("FAIL b2b_pushpop got req/ack %b%b be %b data %h want 11 0100 22",
                           u_if.lsu2dmem_req, u_if.lsu2exu_req_ack, u_if.lsu2dmem_be,
                           u_if.lsu2exu_l_data); end
    step();
    idle();
    set_rsp(SCR1_MEM_RESP_RDY_OK, 32'h44332211);
    #1;
    n_checks++; if (u_if.lsu_busy !== 1'b1 || u_if.lsu2exu_l_data !== 32'h33) begin n_errors++;
      $display("FAIL b2b_pop2 got busy %b data %h want 1 33", u_if.lsu_busy,
               u_if.lsu2exu_l_data); end
    step();
    idle();
    #1;
    n_checks++; if (u_if.lsu_busy !== 1'b0) begin n_errors++;
      $display("FAIL b2b_idle got busy %b want 0", u_if.lsu_busy); end
  endtask

  task automatic test_misalign();
    set_req(SCR1_LSU_CMD_LW, 32'h100, 32'h0, 1'b1);
    step();
    set_req(SCR1_LSU_CMD_SW, 32'h102, 32'hCAFE, 1'b1);
    #1;
    n_checks++; if ({u_if.lsu2exu_req_ack, u_if.lsu2dmem_req, u_if.lsu2exu_rsp_vd} !== 3'b000)
    begin n_errors++; $display("FAIL mis_stall got ack/req/vd %b%b%b want 000",
                               u_if.lsu2exu_req_ack, u_if.lsu2dmem_req, u_if.lsu2exu_rsp_vd); end
    step();
    set_rsp(SCR1_MEM_RESP_RDY_OK, 32'h01020304);
    #1;
    n_checks++; if (u_if.lsu2exu_rsp_vd !== 1'b1 || u_if.lsu2exu_exc !== 1'b0 ||
                    u_if.lsu2exu_req_ack !== 1'b0 || u_if.lsu2exu_l_data !== 32'h01020304) begin
      n_errors++; $display("FAIL mis_rsp_first got vd %b exc %b ack %b data %h want 1 0 0 01020304",
                           u_if.lsu2exu_rsp_vd, u_if.lsu2exu_exc, u_if.lsu2exu_req_ack,
                           u_if.lsu2exu_l_data); end
    step();
    set_rsp(SCR1_MEM_RESP_NOTRDY, 32'h0);
    #1;
    n_checks++; if ({u_if.lsu2exu_rsp_vd, u_if.lsu2exu_exc, u_if.lsu2exu_req_ack,
                     u_if.lsu2dmem_req} !== 4'b1110 ||
                    u_if.lsu2exu_exc_code !== SCR1_EXC_CODE_ST_ADDR_MISALIGN) begin n_errors++;
      $display("FAIL mis_st got vd/exc/ack/req %b%b%b%b code %0d want 1110 6",
               u_if.lsu2exu_rsp_vd, u_if.lsu2exu_exc, u_if.lsu2exu_req_ack, u_if.lsu2dmem_req,
               u_if.lsu2exu_exc_code); end
    step();
    set_req(SCR1_LSU_CMD_LH, 32'h101, 32'h0, 1'b1);
    #1;
    n_checks++; if ({u_if.lsu2exu_exc, u_if.lsu2exu_req_ack, u_if.lsu2dmem_req} !== 3'b110 ||
                    u_if.lsu2exu_exc_code !== SCR1_EXC_CODE_LD_ADDR_MISALIGN ||
                    u_if.lsu2exu_l_data !== 32'h0) begin n_errors++;
      $display("FAIL mis_ld got exc/ack/req %b%b%b code %0d data %h want 110 4 0",
               u_if.lsu2exu_exc, u_if.lsu2exu_req_ack, u_if.lsu2dmem_req,
               u_if.lsu2exu_exc_code, u_if.lsu2exu_l_data); end
    step();
    idle();
  endtask

  task automatic test_fault_and_reset();
    set_req(SCR1_LSU_CMD_LH, 32'h100, 32'h0, 1'b1);
    step();
    idle();
    set_rsp(SCR1_MEM_RESP_RDY_ER, 32'hFFFFFFFF);
    #1;
    n_checks++; if ({u_if.lsu2exu_rsp_vd, u_if.lsu2exu_exc} !== 2'b11 ||
                    u_if.lsu2exu_exc_code !== SCR1_EXC_CODE_LD_ACCESS_FAULT ||
                    u_if.lsu2exu_l_data !== 32'h0) begin n_errors++;
      $display("FAIL ld_fault got vd/exc %b%b code %0d data %h want 11 5 0",
               u_if.lsu2exu_rsp_vd, u_if.lsu2exu_exc, u_if.lsu2exu_exc_code,
               u_if.lsu2exu_l_data); end
    step();
    set_req(SCR1_LSU_CMD_SW, 32'h104, 32'h0, 1'b1);
    step();
    idle();
    set_rsp(SCR1_MEM_RESP_RDY_ER, 32'h0);
    #1;
    n_checks++; if (u_if.lsu2exu_exc !== 1'b1 ||
                    u_if.lsu2exu_exc_code !== SCR1_EXC_CODE_ST_AMO_ACCESS_FAULT) begin
      n_errors++; $display("FAIL st_fault got exc %b code %0d want 1 7", u_if.lsu2exu_exc,
                           u_if.lsu2exu_exc_code); end
    step();
    set_req(SCR1_LSU_CMD_LW, 32'h100, 32'h0, 1'b1);
    step();
    set_req(SCR1_LSU_CMD_LW, 32'h104, 32'h0, 1'b1);
    step();
    idle();
    #1;
    n_checks++; if (u_if.lsu_busy !== 1'b1) begin n_errors++;
      $display("FAIL rst_mid_pre got busy %b want 1", u_if.lsu_busy); end
    rst_n = 1'b0;
    #1;
    n_checks++; if (u_if.lsu_busy !== 1'b0) begin n_errors++;
      $display("FAIL rst_mid_busy got %b want 0", u_if.lsu_busy); end
    step();
    rst_n = 1'b1;
    set_rsp(SCR1_MEM_RESP_RDY_OK, 32'hDEADBEEF);
    #1;
    n_checks++; if (u_if.lsu2exu_rsp_vd !== 1'b0 || u_if.lsu_busy !== 1'b0) begin n_errors++;
      $display("FAIL rst_late_rsp got vd %b busy %b want 0 0", u_if.lsu2exu_rsp_vd,
               u_if.lsu_busy); end
    step();
    idle();
    set_req(SCR1_LSU_CMD_LW, 32'h108, 32'h0, 1'b1);
    step();
    idle();
    set_rsp(SCR1_MEM_RESP_RDY_OK, 32'h5555AAAA);
    #1;
    n_checks++; if (u_if.lsu2exu_l_data !== 32'h5555AAAA) begin n_errors++;
      $display("FAIL rst_after_lw got %h want 5555aaaa", u_if.lsu2exu_l_data); end
    step();
    idle();
  endtask

  initial begin
    n_checks = 0;
    n_errors = 0;
    test_reset();
    test_lw();
    test_load_ext();
    test_store();
    test_back_to_back();
    test_misalign();
    test_fault_and_reset();
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
